// File: rtl/obuf_tag_if.sv
// Handshake bundle between an output-buffer tag controller and the
// load/compute/store engines that share the buffer.
interface obuf_tag_if;
  logic tag_req;
  logic tag_reuse;
  logic tag_bias_prev_sw;
  logic tag_ddr_pe_sw;
  logic tag_flush;
  logic next_sync_compute_tag;
  logic ldmem_tag_done;
  logic compute_tag_done;
  logic stmem_tag_done;

  logic tag_ready;
  logic tag_done;
  logic ldmem_tag_ready;
  logic compute_tag_ready;
  logic compute_bias_prev_sw;
  logic next_compute_tag;
  logic stmem_tag_ready;
  logic stmem_ddr_pe_sw;

  modport master (
    output tag_req, tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw, tag_flush,
           next_sync_compute_tag, ldmem_tag_done, compute_tag_done, stmem_tag_done,
    input  tag_ready, tag_done, ldmem_tag_ready, compute_tag_ready,
           compute_bias_prev_sw, next_compute_tag, stmem_tag_ready, stmem_ddr_pe_sw
  );

  modport slave (
    input  tag_req, tag_reuse, tag_bias_prev_sw, tag_ddr_pe_sw, tag_flush,
           next_sync_compute_tag, ldmem_tag_done, compute_tag_done, stmem_tag_done,
    output tag_ready, tag_done, ldmem_tag_ready, compute_tag_ready,
           compute_bias_prev_sw, next_compute_tag, stmem_tag_ready, stmem_ddr_pe_sw
  );
endinterface

// File: rtl/obuf_tag_fsm.sv
// Output-buffer tag controller: walks one buffer through load, one or more
// compute passes, and store, then frees it for the next block.
//
// state        | meaning
// FREE         | buffer idle, accepts tag_req
// LDMEM        | load engine filling the buffer
// COMPUTE      | one compute pass running
// COMPUTE_DONE | pass finished; replay pending reuses or wait for flush + sync
// STMEM        | store engine writing the buffer back
module obuf_tag_fsm #(
  parameter int REUSE_W = 4
) (
  input  logic      clk,
  input  logic      reset,
  obuf_tag_if.slave bus
);

  typedef enum logic [2:0] {
    FREE         = 3'd0,
    LDMEM        = 3'd1,
    COMPUTE      = 3'd2,
    COMPUTE_DONE = 3'd3,
    STMEM        = 3'd4
  } state_t;

  localparam logic [REUSE_W-1:0] REUSE_MAX = '1;

  state_t             state_q;
  state_t             state_d;
  logic [REUSE_W-1:0] reuse_cnt;
  logic               flush_q;
  logic               bias_q;
  logic               ddr_q;

  logic               alloc;
  logic               reuse_dec;
  logic               flush_ready;
  logic               to_stmem;
  logic               active;

  assign active = (state_q != FREE);

  // Next-state decode plus the one-cycle strobes the datapath registers use.
  always_comb begin
    state_d     = state_q;
    alloc       = 1'b0;
    reuse_dec   = 1'b0;
    flush_ready = 1'b0;
    to_stmem    = 1'b0;
    case (state_q)
      FREE: begin
        if (bus.tag_req) begin
          state_d = LDMEM;
          alloc   = 1'b1;
        end
      end
      LDMEM: begin
        if (bus.ldmem_tag_done) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (bus.compute_tag_done) state_d = COMPUTE_DONE;
      end
      COMPUTE_DONE: begin
        // Pending reuse passes always drain before write-back is considered.
        if (reuse_cnt != '0) begin
          state_d   = COMPUTE;
          reuse_dec = 1'b1;
        end else if (flush_q || bus.tag_flush) begin
          flush_ready = 1'b1;
          if (bus.next_sync_compute_tag) begin
            state_d  = STMEM;
            to_stmem = 1'b1;
          end
        end
      end
      STMEM: begin
        if (bus.stmem_tag_done) state_d = FREE;
      end
      default: state_d = FREE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= FREE;
    else        state_q <= state_d;
  end

  // Reuse counter: saturating up on tag_reuse, down on each replayed pass;
  // both in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      reuse_cnt <= '0;
    end else if (alloc) begin
      reuse_cnt <= '0;
    end else if (active) begin
      if (bus.tag_reuse && !reuse_dec) begin
        if (reuse_cnt != REUSE_MAX) reuse_cnt <= reuse_cnt + REUSE_W'(1);
      end else if (reuse_dec && !bus.tag_reuse) begin
        reuse_cnt <= reuse_cnt - REUSE_W'(1);
      end
    end
  end

  // Sticky flush request, consumed when the buffer moves to store.
  always_ff @(posedge clk) begin
    if (!reset)                      flush_q <= 1'b0;
    else if (alloc || to_stmem)      flush_q <= 1'b0;
    else if (active && bus.tag_flush) flush_q <= 1'b1;
  end

  // Per-block path selects, captured once at allocation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bias_q <= 1'b0;
      ddr_q  <= 1'b0;
    end else if (alloc) begin
      bias_q <= bus.tag_bias_prev_sw;
      ddr_q  <= bus.tag_ddr_pe_sw;
    end
  end

  assign bus.tag_ready            = (state_q == FREE);
  assign bus.tag_done             = (state_q == FREE);
  assign bus.ldmem_tag_ready      = (state_q == LDMEM);
  assign bus.compute_tag_ready    = (state_q == COMPUTE);
  assign bus.stmem_tag_ready      = (state_q == STMEM);
  assign bus.next_compute_tag     = flush_ready;
  assign bus.compute_bias_prev_sw = bias_q;
  assign bus.stmem_ddr_pe_sw      = ddr_q;

endmodule

// File: tb/tb_obuf_tag_fsm.sv
// Directed and randomized checks of obuf_tag_fsm against a phase-level model.
module tb_obuf_tag_fsm;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  obuf_tag_if tag_bus ();

  obuf_tag_fsm #(.REUSE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tag_bus)
  );

  always #5 clk = ~clk;

  // {tag_ready, tag_done, ldmem_rdy, compute_rdy, bias, next_compute, stmem_rdy, ddr}
  logic [7:0] outs;
  assign outs = {tag_bus.tag_ready, tag_bus.tag_done, tag_bus.ldmem_tag_ready,
                 tag_bus.compute_tag_ready, tag_bus.compute_bias_prev_sw,
                 tag_bus.next_compute_tag, tag_bus.stmem_tag_ready, tag_bus.stmem_ddr_pe_sw};

  // Reference model: which phase the buffer is in, how many extra passes are owed.
  localparam int P_IDLE = 0, P_LOAD = 1, P_COMP = 2, P_WAIT = 3, P_STORE = 4;
  localparam int EXTRA_MAX = 15;
  int m_phase = P_IDLE;
  int m_extra = 0;
  bit m_flush = 0, m_bias = 0, m_ddr = 0;

  function automatic logic [7:0] model_outs(input bit flush_in);
    bit nct;
    nct = (m_phase == P_WAIT) && (m_extra == 0) && (m_flush || flush_in);
    return {m_phase == P_IDLE, m_phase == P_IDLE, m_phase == P_LOAD, m_phase == P_COMP,
            m_bias, nct, m_phase == P_STORE, m_ddr};
  endfunction

  task automatic model_edge();
    int nxt, extra_n;
    bit fl_n;
    if (!reset) begin
      m_phase = P_IDLE; m_extra = 0; m_flush = 0; m_bias = 0; m_ddr = 0;
      return;
    end
    nxt = m_phase; extra_n = m_extra; fl_n = m_flush;
    if (m_phase != P_IDLE) begin
      extra_n = extra_n + int'(tag_bus.tag_reuse);
      if (tag_bus.tag_flush) fl_n = 1;
    end
    case (m_phase)
      P_IDLE: if (tag_bus.tag_req) begin
        nxt = P_LOAD; extra_n = 0; fl_n = 0;
        m_bias = tag_bus.tag_bias_prev_sw; m_ddr = tag_bus.tag_ddr_pe_sw;
      end
      P_LOAD:  if (tag_bus.ldmem_tag_done) nxt = P_COMP;
      P_COMP:  if (tag_bus.compute_tag_done) nxt = P_WAIT;
      P_WAIT: begin
        if (m_extra > 0) begin
          nxt = P_COMP; extra_n = extra_n - 1;
        end else if ((m_flush || tag_bus.tag_flush) && tag_bus.next_sync_compute_tag) begin
          nxt = P_STORE; fl_n = 0;
        end
      end
      P_STORE: if (tag_bus.stmem_tag_done) nxt = P_IDLE;
      default: nxt = P_IDLE;
    endcase
    if (extra_n > EXTRA_MAX) extra_n = EXTRA_MAX;
    m_phase = nxt; m_extra = extra_n; m_flush = fl_n;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    tag_bus.tag_req = 0; tag_bus.tag_reuse = 0; tag_bus.tag_bias_prev_sw = 0;
    tag_bus.tag_ddr_pe_sw = 0; tag_bus.tag_flush = 0; tag_bus.next_sync_compute_tag = 0;
    tag_bus.ldmem_tag_done = 0; tag_bus.compute_tag_done = 0; tag_bus.stmem_tag_done = 0;
  endtask

  // Check current outputs against the model, clock once, then drop the pulses.
  task automatic run(input string tag);
    #1;
    chk(tag, outs, model_outs(tag_bus.tag_flush));
    @(posedge clk);
    model_edge();
    #1;
    clear_inputs();
  endtask

  task automatic expect_now(input string tag, input logic [7:0] exp);
    #1;
    chk(tag, outs, exp);
  endtask

  initial begin
    clear_inputs();
    reset = 0;
    repeat (2) @(posedge clk);
    model_edge();
    #1 reset = 1;
    expect_now("reset_outputs", 8'hC0);

    // Allocate with bias=1, ddr=0.
    tag_bus.tag_req = 1; tag_bus.tag_bias_prev_sw = 1; tag_bus.tag_ddr_pe_sw = 0;
    run("alloc");
    expect_now("in_ldmem", 8'h28);
    tag_bus.tag_req = 1; tag_bus.tag_bias_prev_sw = 0; tag_bus.tag_ddr_pe_sw = 1;
    run("req_in_ldmem");
    expect_now("req_ignored", 8'h28);
    tag_bus.ldmem_tag_done = 1;
    run("ld_done");
    expect_now("in_compute", 8'h18);

    // Two reuse pulses, then three passes.
    tag_bus.tag_reuse = 1; run("reuse1");
    tag_bus.tag_reuse = 1; run("reuse2");
    for (int k = 0; k < 3; k++) begin
      tag_bus.compute_tag_done = 1;
      run("pass_done");
      expect_now("in_compute_done", 8'h08);
      run("pass_wait");
      if (k < 2) expect_now("reentered_compute", 8'h18);
      else       expect_now("stays_compute_done", 8'h08);
    end

    // Sync without flush is ignored; flush raises next_compute_tag combinationally.
    tag_bus.next_sync_compute_tag = 1;
    run("sync_no_flush");
    expect_now("held_no_flush", 8'h08);
    tag_bus.tag_flush = 1;
    expect_now("flush_comb", 8'h0C);
    run("flush_pulse");
    expect_now("flush_latched", 8'h0C);
    tag_bus.next_sync_compute_tag = 1;
    run("sync_go");
    expect_now("in_stmem", 8'h0A);
    tag_bus.stmem_tag_done = 1;
    run("st_done");
    expect_now("freed", 8'hC8);

    // Second block: flush during COMPUTE, then reset while storing.
    tag_bus.tag_req = 1; tag_bus.tag_bias_prev_sw = 0; tag_bus.tag_ddr_pe_sw = 1;
    run("alloc2");
    expect_now("alloc2_ldmem", 8'h21);
    tag_bus.ldmem_tag_done = 1; run("ld_done2");
    tag_bus.tag_flush = 1; run("flush_in_compute");
    expect_now("compute_flushed", 8'h11);
    tag_bus.compute_tag_done = 1; run("pass_done2");
    expect_now("next_compute_tag", 8'h05);
    tag_bus.next_sync_compute_tag = 1; run("sync2");
    expect_now("in_stmem2", 8'h03);
    reset = 0;
    run("reset_in_stmem");
    reset = 1;
    expect_now("after_reset", 8'hC0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tag_bus.tag_req               = ($urandom_range(0, 3) == 0);
      tag_bus.tag_reuse             = ($urandom_range(0, 2) == 0);
      tag_bus.tag_bias_prev_sw      = $urandom_range(0, 1);
      tag_bus.tag_ddr_pe_sw         = $urandom_range(0, 1);
      tag_bus.tag_flush             = ($urandom_range(0, 7) == 0);
      tag_bus.next_sync_compute_tag = ($urandom_range(0, 2) == 0);
      tag_bus.ldmem_tag_done        = ($urandom_range(0, 2) == 0);
      tag_bus.compute_tag_done      = ($urandom_range(0, 2) == 0);
      tag_bus.stmem_tag_done        = ($urandom_range(0, 2) == 0);
      reset                         = ($urandom_range(0, 199) != 0);
      run("random");
    end
    reset = 1;
    run("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
